// File: rtl/display_resultado_division.sv
// Converts the divider's quotient/remainder to BCD with a sequential double-dabble
// and scans them onto a 4-digit multiplexed active-low 7-segment display.
module display_resultado_division #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [6:0]  cociente,
  input  logic [6:0]  resto,
  input  logic        sel_resto,
  output logic        busy,
  output logic        bcd_valid,
  output logic [11:0] bcd_coc,
  output logic [11:0] bcd_res,
  output logic [3:0]  anodo,
  output logic [6:0]  seg
);

  localparam int unsigned BIN_W  = 7;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned ITER_W = 3;
  localparam int unsigned REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {IDLE, CONV, STORE} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_coc, bin_res;
  logic [BCD_W-1:0]    work_coc, work_res;
  logic [BCD_W-1:0]    adj_coc_c, adj_res_c;
  logic [ITER_W-1:0]   iter;
  logic [REF_W-1:0]    ref_cnt;
  logic [1:0]          idx;
  logic [BCD_W-1:0]    sel_val_c;
  logic [6:0]          seg_c;

  // Add-3 correction on every BCD nibble that is 5 or more
  function automatic logic [11:0] dabble_adj(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: done is only honoured in IDLE; seven iterations then store
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (done) state_d = CONV;
      CONV:    if (iter == ITER_W'(6)) state_d = STORE;
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign adj_coc_c = dabble_adj(work_coc);
  assign adj_res_c = dabble_adj(work_res);

  // Conversion datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      bcd_coc   <= '0;
      bcd_res   <= '0;
      bin_coc   <= '0;
      bin_res   <= '0;
      work_coc  <= '0;
      work_res  <= '0;
      iter      <= '0;
    end else begin
      busy      <= (state_d != IDLE);
      bcd_valid <= (state_q == STORE);
      case (state_q)
        IDLE: begin
          if (done) begin
            bin_coc  <= cociente;
            bin_res  <= resto;
            work_coc <= '0;
            work_res <= '0;
            iter     <= '0;
          end
        end
        CONV: begin
          work_coc <= {adj_coc_c[BCD_W-2:0], bin_coc[BIN_W-1]};
          work_res <= {adj_res_c[BCD_W-2:0], bin_res[BIN_W-1]};
          bin_coc  <= {bin_coc[BIN_W-2:0], 1'b0};
          bin_res  <= {bin_res[BIN_W-2:0], 1'b0};
          iter     <= iter + ITER_W'(1);
        end
        STORE: begin
          bcd_coc <= work_coc;
          bcd_res <= work_res;
        end
        default: ;
      endcase
    end
  end

  // Refresh timer and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // Digit content with leading-zero blanking
  always_comb begin
    sel_val_c = sel_resto ? bcd_res : bcd_coc;
    seg_c     = SEG_BLANK;
    case (idx)
      2'd3: seg_c = sel_resto ? SEG_R : SEG_C;
      2'd2: seg_c = (sel_val_c[11:8] == 4'd0) ? SEG_BLANK : digit_seg(sel_val_c[11:8]);
      2'd1: seg_c = (sel_val_c[11:4] == 8'd0) ? SEG_BLANK : digit_seg(sel_val_c[7:4]);
      default: seg_c = digit_seg(sel_val_c[3:0]);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anodo <= 4'b1111;
      seg   <= SEG_BLANK;
    end else begin
      anodo <= ~(4'b0001 << idx);
      seg   <= seg_c;
    end
  end

endmodule

// File: tb/tb_display_resultado_division.sv
// Scoreboard bench for display_resultado_division: directed conversions, display scans,
// done-while-busy and reset-mid-conversion cases.
module tb_display_resultado_division;

  localparam int unsigned RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [6:0]  cociente;
  logic [6:0]  resto;
  logic        sel_resto;
  logic        busy;
  logic        bcd_valid;
  logic [11:0] bcd_coc;
  logic [11:0] bcd_res;
  logic [3:0]  anodo;
  logic [6:0]  seg;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  logic [23:0] sb_q[$];
  logic [23:0] sb_e;

  display_resultado_division #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .done(done), .cociente(cociente), .resto(resto),
    .sel_resto(sel_resto), .busy(busy), .bcd_valid(bcd_valid), .bcd_coc(bcd_coc),
    .bcd_res(bcd_res), .anodo(anodo), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every bcd_valid pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (rst && bcd_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got coc=0x%0h res=0x%0h expected no pulse", bcd_coc, bcd_res);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_bcd_coc", int'(bcd_coc), int'(sb_e[23:12]));
        check("sb_bcd_res", int'(bcd_res), int'(sb_e[11:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion; optionally fires a second done sampled at E3
  task automatic run_conv(input logic [6:0] c, input logic [6:0] r,
                          input logic [11:0] ec, input logic [11:0] er, input bit inject);
    sb_q.push_back({ec, er});
    done = 1'b1; cociente = c; resto = r;
    tick();
    done = 1'b0;
    check("busy_after_e0", int'(busy), 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("busy_conv", int'(busy), 1);
      check("no_early_valid", int'(bcd_valid), 0);
      if (inject && i == 2) begin
        done = 1'b1; cociente = 7'd7; resto = 7'd3;
      end
      if (inject && i == 3) done = 1'b0;
    end
    tick();
    check("valid_at_e8", int'(bcd_valid), 1);
    check("busy_after_e8", int'(busy), 0);
    tick();
    check("valid_one_cycle", int'(bcd_valid), 0);
  endtask

  // Align to digit 0 and check one full scan (4 digits x RD cycles)
  task automatic scan(input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3);
    logic [3:0] prev;
    logic [3:0] one;
    logic [6:0] exp_seg;
    bit         found;
    found = 1'b0;
    one   = 4'b0001;
    for (int t = 0; t < 40 && !found; t++) begin
      prev = anodo;
      tick();
      if (anodo == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    if (!found) begin
      check("scan_align", int'(anodo), 14);
    end else begin
      for (int k = 0; k < 4 * RD; k++) begin
        case (k / RD)
          0:       exp_seg = e0;
          1:       exp_seg = e1;
          2:       exp_seg = e2;
          default: exp_seg = e3;
        endcase
        check("scan_anodo", int'(anodo), int'(~(one << (k / RD)) & 4'hF));
        check("scan_seg", int'(seg), int'(exp_seg));
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b0; done = 1'b0; cociente = '0; resto = '0; sel_resto = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(bcd_valid), 0);
    check("rst_bcd_coc", int'(bcd_coc), 0);
    check("rst_bcd_res", int'(bcd_res), 0);
    check("rst_anodo", int'(anodo), 'hF);
    check("rst_seg", int'(seg), 'h7F);
    tick();
    check("post_rst_anodo", int'(anodo), 'hE);
    check("post_rst_seg", int'(seg), 'h40);

    run_conv(7'd14, 7'd2, 12'h014, 12'h002, 1'b0);

    run_conv(7'd127, 7'd126, 12'h127, 12'h126, 1'b0);
    scan(7'b1111000, 7'b0100100, 7'b1111001, 7'b1000110);

    sel_resto = 1'b1;
    run_conv(7'd0, 7'd9, 12'h000, 12'h009, 1'b0);
    scan(7'b0010000, 7'b1111111, 7'b1111111, 7'b0101111);
    sel_resto = 1'b0;
    scan(7'b1000000, 7'b1111111, 7'b1111111, 7'b1000110);

    run_conv(7'd100, 7'd5, 12'h100, 12'h005, 1'b1);
    repeat (12) tick();
    check("single_valid_busy_case", n_valid, 4);

    // Reset asserted shortly after E4 of a 99/1 conversion
    done = 1'b1; cociente = 7'd99; resto = 7'd1;
    tick();
    done = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_bcd_coc", int'(bcd_coc), 0);
    check("midrst_bcd_res", int'(bcd_res), 0);
    tick();
    rst = 1'b1;
    repeat (12) tick();
    check("midrst_no_valid", n_valid, 4);

    run_conv(7'd45, 7'd6, 12'h045, 12'h006, 1'b0);
    repeat (3) tick();
    check("sb_drained", sb_q.size(), 0);
    check("total_valid", n_valid, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_resultado_division.md
Name: display_resultado_division

Overview:
- Downstream consumer of the 7-bit restoring divider.
- On the divider's one-cycle `done` pulse, it captures `cociente` and `resto` and converts both to 3-digit BCD with a sequential double-dabble.
- It then drives a 4-digit multiplexed active-low 7-segment display: a mode letter on digit 3 and the selected value on digits 2..0.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays lit; legal range ≥2; sims use 4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- done  input  1  divider completion pulse; operands valid when high
- cociente  input  7  quotient from divider
- resto  input  7  remainder from divider
- sel_resto  input  1  0 = show quotient, 1 = show remainder
- busy  output  1  high while a conversion is in progress (states CONV, STORE)
- bcd_valid  output  1  one-cycle pulse when the display registers update
- bcd_coc  output  12  quotient BCD {hundreds, tens, units}
- bcd_res  output  12  remainder BCD {hundreds, tens, units}
- anodo  output  4  digit enables, active-low one-hot
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All flops are cleared on rst=0 regardless of state.
- Reset values:
  - state=IDLE, busy=0, bcd_valid=0
  - bcd_coc=0, bcd_res=0
  - refresh counter=0, digit index=0
  - anodo=4'b1111, seg=7'b1111111
- FSM states: IDLE, CONV, STORE.
- IDLE:
  - busy=0.
  - At edge E0 with done=1: latch cociente/resto into shift sources, clear both 12-bit BCD work registers, set iteration count=0, go to CONV.
- CONV:
  - busy=1.
  - Each edge E1..E7 performs one iteration for both values in parallel: every BCD nibble ≥5 gets +3, then {bcd,bin} shifts left by 1 and the binary MSB enters the units LSB.
  - Count increments each iteration. At E7 (7th iteration, count==6 before the edge), go to STORE.
- STORE:
  - busy=1.
  - At E8, copy the work registers to bcd_coc/bcd_res and go to IDLE.
  - bcd_valid is high for exactly the cycle following E8.
- Latency: done sampled at E0 → outputs updated at E8 (8 clocks).
- done while busy, or while in STORE, is ignored; no queuing. done held high across multiple IDLE cycles retriggers each time IDLE is re-entered.
- Reset mid-conversion: returns to IDLE and clears bcd_coc/bcd_res. A pending conversion is discarded.
- Width rules: inputs 0..127, so hundreds ≤1 and every nibble stays 0..9. No overflow is possible.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→3→0 (2-bit wrap).
- Display output registers: anodo and seg are registered, computed from the current index, sel_resto and the bcd registers. They change one clock after the inputs change.
  - anodo[i]=0 only for i==index.
- Digit content:
  - Digit 3: letter 'C' (1000110) when sel_resto=0, 'r' (0101111) when sel_resto=1.
  - Digit 2: hundreds, blank (1111111) if zero.
  - Digit 1: tens, blank if hundreds and tens are both zero.
  - Digit 0: units, always shown.
- Digit encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- sel_resto may change at any time; the display follows on the next refresh-registered cycle without corrupting the BCD registers.
- The display keeps scanning old values during a conversion and switches at E8.

Test Plan:
- Reset: hold rst=0 for 3 clk, release → busy=0, bcd_coc=bcd_res=0, anodo=1111 in the first post-reset cycle, then 1110 with seg=1000000 ('0'). REFRESH_DIV=4.
- Basic conversion: pulse done with cociente=14, resto=2 → bcd_valid pulses 8 clk after E0; bcd_coc=12'h014, bcd_res=12'h002; busy high from E0+1 through E8.
- Maximum value: cociente=127, resto=126 → bcd_coc=12'h127, bcd_res=12'h126. With sel_resto=0, a scan shows digits 3..0 = C,1,2,7 with anodo cycling 1110,1101,1011,0111 every 4 clk.
- Blanking and mode: cociente=0, resto=9, sel_resto=1 → digit3='r' (0101111), digits 2..1 blank (1111111), digit0='9' (0010000). With sel_resto=0 → digit0='0' and digits 2..1 blank.
- done while busy: done with 100/5 at E0, second done with 7/3 at E3 → result 12'h100/12'h005 only, single bcd_valid pulse.
- Reset mid-operation: done with 99/1, assert rst at E4 → bcd_coc=bcd_res=0, busy=0, no bcd_valid. A new done with 45/6 then yields 12'h045/12'h006 after 8 clk.
